mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port of the multi-cycle core between
//  two requesters: the CPU (fetch + lw/sw) and a DMA/loader port used to preload or dump memory.
//  Sits between the core datapath (its IorD-muxed address path) and the memory macro.
//  One outstanding access at a time. Round-robin fairness. Per-requester done pulse for stalling.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  MEM_LAT  1   memory read latency in cycles, mem_en -> mem_rdata valid; legal range 1..15
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  cpu_req    in   1   CPU request; held with a stable command until cpu_gnt
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   AW  byte address
//  cpu_wdata  in   DW  write data
//  cpu_gnt    out  1   command accepted this cycle
//  cpu_done   out  1   one-cycle pulse; access complete; cpu_rdata valid if read
//  cpu_rdata  out  DW  read data
//  dma_req/dma_we/dma_addr/dma_wdata/dma_gnt/dma_done/dma_rdata: same as cpu_*, DMA side
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - FSM states: IDLE and BUSY. Registers: state, owner (CPU/DMA), last (CPU/DMA), cnt[3:0].
//  - Reset, synchronous: state=IDLE, cnt=0, last=DMA, so the CPU wins the first tie.
//    While reset is high, all gnt, done and mem_en outputs are forced to 0.
//  - IDLE with any request:
//      - Pick a winner. Same cycle: mem_en=1, mem_we/addr/wdata = winner's command,
//        winner's gnt=1 (combinational from state+req).
//      - Next state BUSY, owner=winner, last=winner, cnt=MEM_LAT-1.
//  - IDLE with no request: mem_en=0 and mem_we=0. mem_addr/mem_wdata are don't-care but must not be X.
//  - BUSY: cnt decrements each cycle. When cnt==0:
//      - owner's done=1 and owner's rdata=mem_rdata.
//      - Next state IDLE.
//  - Latency: gnt at cycle T, done at T+MEM_LAT. Earliest next grant is T+MEM_LAT+1.
//    Writes use the same timing as reads, so the core sees uniform latency.
//  - cpu_rdata and dma_rdata are registered and hold their last read value.
//    A write does not update rdata.
//  - Arbitration: a lone requester is granted immediately. When both request in IDLE,
//    the requester != last wins.
//  - A requester may drop req after gnt. req is sampled only in IDLE.
//    A req held through done is treated as a new request.
//  - No grant is issued in BUSY. A new req arriving in BUSY waits and is not lost.
//  - Reset mid-access: the in-flight access is abandoned, no done is issued,
//    and a late mem_rdata is ignored.
//  - gnt and done are mutually exclusive per requester in any cycle.
//    At most one gnt is asserted per cycle.
// CONFIGURATION
//  MEM_ARB_CPU_PRIO_EN
//    - defined: the CPU always wins a simultaneous request, and last is ignored.
//      The DMA is served only when cpu_req=0 in IDLE.
//    - undefined (default): round-robin as specified above.
// STRUCTURE
//  - mem_arb_pkg:
//      - state enum {IDLE, BUSY}
//      - owner enum {OWN_CPU, OWN_DMA}
//      - localparam CNT_W=4
//  - Sub-module rr_arb2:
//      - purely combinational 2-way picker
//      - inputs: req[1:0], last, prio_fixed
//      - outputs: one-hot grant
//  - Top level holds the FSM, counter, muxes and rdata registers.
// TESTING (MEM_LAT=1 unless noted; memory model returns mem_rdata = addr ^ 32'hA5A5A5A5)
//  1. Reset, then cpu_req read addr 0x10 at T:
//     cpu_gnt@T, mem_en@T, cpu_done@T+1 with cpu_rdata=0xA5A5A5B5; dma_* outputs stay 0.
//  2. cpu_req and dma_req both asserted at T0 and held:
//     grant order CPU, DMA, CPU, DMA at T0, T0+2, T0+4, T0+6.
//     With MEM_ARB_CPU_PRIO_EN defined: CPU at every grant, DMA never granted.
//  3. dma write 0x20 = 0xDEADBEEF:
//     mem_we=1 and mem_wdata=0xDEADBEEF at gnt; dma_done one cycle later;
//     dma_rdata holds its previous value.
//  4. MEM_LAT=3, cpu read at T, dma_req raised at T+1:
//     cpu_done@T+3, no dma_gnt before T+4, dma_gnt@T+4.
//  5. Reset asserted at T+1 during a MEM_LAT=3 read granted at T:
//     no cpu_done ever issued; the next simultaneous request grants the CPU.
//  6. Random req/we/addr for 10k cycles against a scoreboard:
//     at most one gnt per cycle, every gnt matched by exactly one done,
//     no request starves beyond 2*(MEM_LAT+1) cycles in round-robin mode.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, DMA and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_done;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // master: requesters plus memory macro; slave: the arbiter
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way picker; grant[0]=CPU, grant[1]=DMA
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_fixed,
  output logic [1:0] grant
);

  // on a tie the requester not served last wins, unless CPU priority is fixed
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio_fixed || last) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between CPU and DMA, one access in flight
// MEM_ARB_CPU_PRIO_EN: when defined the CPU always wins a tie instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

`ifdef MEM_ARB_CPU_PRIO_EN
  localparam logic PRIO_FIXED = 1'b1;
`else
  localparam logic PRIO_FIXED = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e          state;
  owner_e          owner;
  owner_e          last;
  logic [CNT_W-1:0] cnt;
  logic            owner_we;
  logic [DW-1:0]   cpu_rdata_q;
  logic [DW-1:0]   dma_rdata_q;

  logic [1:0]      req;
  logic [1:0]      pick;
  logic [1:0]      gnt;
  logic            fin;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;

  assign req = {bus.dma_req, bus.cpu_req};

  rr_arb2 u_pick (
    .req        (req),
    .last       (last == OWN_DMA),
    .prio_fixed (PRIO_FIXED),
    .grant      (pick)
  );

  assign gnt = (state == IDLE && !reset) ? pick : 2'b00;
  assign fin = (state == BUSY) && (cnt == '0) && !reset;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[1]) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end else if (gnt[0]) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end
  end

  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign bus.cpu_gnt  = gnt[0];
  assign bus.dma_gnt  = gnt[1];
  assign bus.cpu_done = fin && (owner == OWN_CPU);
  assign bus.dma_done = fin && (owner == OWN_DMA);

  // read data is presented in the done cycle, then held from the capture register
  assign bus.cpu_rdata = (bus.cpu_done && !owner_we) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata = (bus.dma_done && !owner_we) ? bus.mem_rdata : dma_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      last        <= OWN_DMA;
      cnt         <= '0;
      owner_we    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            state    <= BUSY;
            owner    <= pick[1] ? OWN_DMA : OWN_CPU;
            last     <= pick[1] ? OWN_DMA : OWN_CPU;
            cnt      <= CNT_INIT;
            owner_we <= sel_we;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (!owner_we) begin
              if (owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
              else                  dma_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vectors plus random scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5A5A5;
`ifdef MEM_ARB_CPU_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst1, rst3;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(b1));
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(b3));

  // memory models: data = addr ^ K, MEM_LAT cycles after mem_en, garbage otherwise
  logic [31:0] p1 = 32'h0;
  logic [31:0] p3 [3] = '{32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    p1    <= b1.mem_en ? (b1.mem_addr ^ K) : 32'h0BAD0BAD;
    p3[0] <= b3.mem_en ? (b3.mem_addr ^ K) : 32'h0BAD0BAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0; b1.cpu_wdata = 32'h0;
    b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = 32'h0; b1.dma_wdata = 32'h0;
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h0; b3.cpu_wdata = 32'h0;
    b3.dma_req = 1'b0; b3.dma_we = 1'b0; b3.dma_addr = 32'h0; b3.dma_wdata = 32'h0;
  endtask

  typedef struct {
    logic        cr, cw; logic [31:0] ca, cd;
    logic        dr, dw; logic [31:0] da, dd;
    logic [1:0]  gnt;    logic we; logic [31:0] addr, wdata;
    logic [31:0] crd, drd;
  } vec_t;

  vec_t vt [7];

  localparam logic [31:0] CRD_A = 32'hA5A5A5B5;
  localparam logic [31:0] DRD_A = 32'hA5A5A5E5;
  localparam logic [31:0] CRD_B = 32'hA5A5A4A5;

  // random-test scoreboard state
  logic        rq [2], rw [2], gs [2], pend [2], isrd [2];
  logic [31:0] ra [2], rdd [2], erd [2];
  int          due [2], wt [2];

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              2'b01, 1'b0, 32'h10, 32'h0, CRD_A, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
              2'b10, 1'b0, 32'h40, 32'h0, CRD_A, DRD_A};
    vt[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF,
              2'b10, 1'b1, 32'h20, 32'hDEADBEEF, CRD_A, DRD_A};
    vt[3] = '{1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
              2'b01, 1'b0, 32'h100, 32'h0, CRD_B, DRD_A};
`ifdef MEM_ARB_CPU_PRIO_EN
    vt[4] = '{1'b1, 1'b1, 32'h300, 32'h11111111, 1'b1, 1'b0, 32'h400, 32'h0,
              2'b01, 1'b1, 32'h300, 32'h11111111, CRD_B, DRD_A};
    vt[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              2'b00, 1'b0, 32'h0, 32'h0, CRD_B, DRD_A};
    vt[6] = '{1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0,
              2'b01, 1'b1, 32'h8, 32'hCAFEF00D, CRD_B, DRD_A};
`else
    vt[4] = '{1'b1, 1'b1, 32'h300, 32'h11111111, 1'b1, 1'b0, 32'h400, 32'h0,
              2'b10, 1'b0, 32'h400, 32'h0, CRD_B, 32'hA5A5A1A5};
    vt[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              2'b00, 1'b0, 32'h0, 32'h0, CRD_B, 32'hA5A5A1A5};
    vt[6] = '{1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0,
              2'b01, 1'b1, 32'h8, 32'hCAFEF00D, CRD_B, 32'hA5A5A1A5};
`endif

    // reset with both requests up: everything must stay quiet
    rst1 = 1'b1; rst3 = 1'b1;
    idle_all();
    b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt", 32'({b1.dma_gnt, b1.cpu_gnt}), 32'h0);
    chk("rst_mem_en", 32'(b1.mem_en), 32'h0);
    chk("rst_done", 32'({b1.dma_done, b1.cpu_done}), 32'h0);
    tick();
    rst1 = 1'b0; rst3 = 1'b0;
    idle_all();

    // table vectors on MEM_LAT=1: grant cycle then done cycle
    for (int i = 0; i < 7; i++) begin
      tick();
      b1.cpu_req = vt[i].cr; b1.cpu_we = vt[i].cw; b1.cpu_addr = vt[i].ca; b1.cpu_wdata = vt[i].cd;
      b1.dma_req = vt[i].dr; b1.dma_we = vt[i].dw; b1.dma_addr = vt[i].da; b1.dma_wdata = vt[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'({b1.dma_gnt, b1.cpu_gnt}), 32'(vt[i].gnt));
      chk($sformatf("v%0d_mem_en", i), 32'(b1.mem_en), 32'(|vt[i].gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(b1.mem_we), 32'(vt[i].we));
      if (|vt[i].gnt) chk($sformatf("v%0d_mem_addr", i), b1.mem_addr, vt[i].addr);
      if (vt[i].we)   chk($sformatf("v%0d_mem_wdata", i), b1.mem_wdata, vt[i].wdata);
      tick();
      idle_all();
      @(negedge clk);
      chk($sformatf("v%0d_done", i), 32'({b1.dma_done, b1.cpu_done}), 32'(vt[i].gnt));
      chk($sformatf("v%0d_gnt_in_done", i), 32'({b1.dma_gnt, b1.cpu_gnt}), 32'h0);
      chk($sformatf("v%0d_cpu_rdata", i), b1.cpu_rdata, vt[i].crd);
      chk($sformatf("v%0d_dma_rdata", i), b1.dma_rdata, vt[i].drd);
    end

    // both held from a fresh reset: alternate (or CPU only with fixed priority)
    tick(); rst1 = 1'b1;
    tick(); rst1 = 1'b0;
    b1.cpu_req = 1'b1; b1.cpu_addr = 32'h50;
    b1.dma_req = 1'b1; b1.dma_addr = 32'h60;
    begin
      logic [1:0] prev;
      prev = 2'b00;
      for (int c = 0; c < 8; c++) begin
        logic [1:0] eg;
        if (c > 0) tick();
        eg = (c % 2 == 1) ? 2'b00 : ((RR && (c % 4 == 2)) ? 2'b10 : 2'b01);
        @(negedge clk);
        chk($sformatf("t2_gnt_c%0d", c), 32'({b1.dma_gnt, b1.cpu_gnt}), 32'(eg));
        chk($sformatf("t2_done_c%0d", c), 32'({b1.dma_done, b1.cpu_done}), 32'(prev));
        prev = eg;
      end
    end
    tick();
    idle_all();

    // MEM_LAT=3: DMA arriving while busy waits for the CPU to finish
    for (int c = 0; c < 8; c++) begin
      tick();
      b3.cpu_req = (c == 0); b3.cpu_we = 1'b0; b3.cpu_addr = 32'h10;
      b3.dma_req = (c >= 1 && c <= 4); b3.dma_we = 1'b0; b3.dma_addr = 32'h24;
      @(negedge clk);
      chk($sformatf("t4_cpu_gnt_c%0d", c), 32'(b3.cpu_gnt), 32'(c == 0));
      chk($sformatf("t4_cpu_done_c%0d", c), 32'(b3.cpu_done), 32'(c == 3));
      chk($sformatf("t4_dma_gnt_c%0d", c), 32'(b3.dma_gnt), 32'(c == 4));
      chk($sformatf("t4_dma_done_c%0d", c), 32'(b3.dma_done), 32'(c == 7));
      if (c == 3) chk("t4_cpu_rdata", b3.cpu_rdata, CRD_A);
      if (c == 4) chk("t4_mem_addr", b3.mem_addr, 32'h24);
      if (c == 7) chk("t4_dma_rdata", b3.dma_rdata, 32'hA5A5A581);
    end

    // MEM_LAT=3: reset mid-access abandons it and restores CPU-first tie-break
    for (int c = 0; c <= 10; c++) begin
      tick();
      rst3 = (c == 1);
      b3.cpu_req = (c == 0 || c == 7); b3.cpu_addr = 32'h30;
      b3.dma_req = (c == 7);           b3.dma_addr = 32'h34;
      @(negedge clk);
      chk($sformatf("t5_cpu_done_c%0d", c), 32'(b3.cpu_done), 32'(c == 10));
      chk($sformatf("t5_dma_done_c%0d", c), 32'(b3.dma_done), 32'h0);
      if (c == 0) chk("t5_first_gnt", 32'(b3.cpu_gnt), 32'h1);
      if (c == 1) chk("t5_rst_mem_en", 32'(b3.mem_en), 32'h0);
      if (c == 7) chk("t5_tie_gnt", 32'({b3.dma_gnt, b3.cpu_gnt}), 32'h1);
    end
    tick();
    idle_all();
    tick();

    // random traffic on MEM_LAT=1 against a scoreboard
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; rw[r] = 1'b0; gs[r] = 1'b0; pend[r] = 1'b0; isrd[r] = 1'b0;
      ra[r] = 32'h0; rdd[r] = 32'h0; erd[r] = 32'h0; due[r] = 0; wt[r] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [1:0] g, d;
      tick();
      for (int r = 0; r < 2; r++) begin
        if (cyc < 9990 && (!rq[r] || gs[r])) begin
          rq[r]  = ($urandom_range(0, 2) != 0);
          rw[r]  = $urandom_range(0, 1) == 1;
          ra[r]  = $urandom;
          rdd[r] = $urandom;
        end else if (cyc >= 9990 && gs[r]) begin
          rq[r] = 1'b0;
        end
      end
      b1.cpu_req = rq[0]; b1.cpu_we = rw[0]; b1.cpu_addr = ra[0]; b1.cpu_wdata = rdd[0];
      b1.dma_req = rq[1]; b1.dma_we = rw[1]; b1.dma_addr = ra[1]; b1.dma_wdata = rdd[1];
      @(negedge clk);
      g = {b1.dma_gnt, b1.cpu_gnt};
      d = {b1.dma_done, b1.cpu_done};
      chk("rnd_two_gnts", 32'(g == 2'b11), 32'h0);
      for (int r = 0; r < 2; r++) begin
        logic ed;
        ed = pend[r] && (due[r] == cyc);
        chk($sformatf("rnd_done_r%0d", r), 32'(d[r]), 32'(ed));
        if (ed) begin
          pend[r] = 1'b0;
          if (isrd[r])
            chk($sformatf("rnd_rdata_r%0d", r), (r == 0) ? b1.cpu_rdata : b1.dma_rdata, erd[r]);
        end
        if (g[r]) begin
          chk($sformatf("rnd_gnt_noreq_r%0d", r), 32'(rq[r]), 32'h1);
          chk($sformatf("rnd_addr_r%0d", r), b1.mem_addr, ra[r]);
          pend[r] = 1'b1;
          due[r]  = cyc + 1;
          isrd[r] = !rw[r];
          erd[r]  = ra[r] ^ K;
          wt[r]   = 0;
        end else if (rq[r]) begin
          wt[r]++;
          if (RR || r == 0) chk($sformatf("rnd_starve_r%0d", r), 32'(wt[r] > 4), 32'h0);
        end
        gs[r] = g[r];
      end
    end
    chk("rnd_drain", 32'({pend[1], pend[0]}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
